// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// Optional DIV_EARLY_OUT_EN: special cases and |a|<|b| bypass the iterations.
module div_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            sign_i,
  input  logic            word_i,
  input  logic            rem_i,
  output logic            ready_o,
  output logic            out_valid_o,
  output logic [XLEN-1:0] result_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, aext_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic            word_q, selrem_q, negq_q, negr_q, dz_q, ov_q, ready_q, vld_q;

  function automatic logic [XLEN-1:0] sext(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Override value; the final branch is the |a|<|b| early-out case.
  function automatic logic [XLEN-1:0] special(input logic dz, input logic ov,
                                              input logic r, input logic [XLEN-1:0] ax);
    if (dz)      return r ? ax : '1;
    else if (ov) return r ? '0 : ax;
    else         return r ? ax : '0;
  endfunction

  // Acceptance-time operand decode
  logic            a_msb, b_msb, dz, ov;
  logic [31:0]     a32m, b32m;
  logic [XLEN-1:0] a64m, b64m, a_mag, b_mag, quo_init, aext;

  always_comb begin
    a_msb    = word_i ? a_i[31] : a_i[XLEN-1];
    b_msb    = word_i ? b_i[31] : b_i[XLEN-1];
    a32m     = (sign_i && a_i[31]) ? -a_i[31:0] : a_i[31:0];
    b32m     = (sign_i && b_i[31]) ? -b_i[31:0] : b_i[31:0];
    a64m     = (sign_i && a_i[XLEN-1]) ? -a_i : a_i;
    b64m     = (sign_i && b_i[XLEN-1]) ? -b_i : b_i;
    a_mag    = word_i ? {{(XLEN-32){1'b0}}, a32m} : a64m;
    b_mag    = word_i ? {{(XLEN-32){1'b0}}, b32m} : b64m;
    // Word dividend sits in the top half so the shift-out bit is always quo[XLEN-1].
    quo_init = word_i ? {a32m, {(XLEN-32){1'b0}}} : a64m;
    aext     = sext(word_i, a_i);
    dz       = word_i ? (b_i[31:0] == 32'd0) : (b_i == '0);
    ov       = sign_i && (word_i ? (a_i[31:0] == 32'h8000_0000 && b_i[31:0] == 32'hFFFF_FFFF)
                                 : (a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1));
  end

`ifdef DIV_EARLY_OUT_EN
  logic lt;
  assign lt = a_mag < b_mag;
`endif

  // One restoring step
  logic [XLEN:0]   trial, diff;
  logic [XLEN-1:0] qv, rv, fix_res;

  always_comb begin
    trial   = {rem_q, quo_q[XLEN-1]};
    diff    = trial - {1'b0, dvs_q};
    qv      = negq_q ? -quo_q : quo_q;
    rv      = negr_q ? -rem_q : rem_q;
    fix_res = (dz_q || ov_q) ? special(dz_q, ov_q, selrem_q, aext_q)
                             : sext(word_q, selrem_q ? rv : qv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      aext_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      word_q   <= 1'b0;
      selrem_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      ready_q  <= 1'b1;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (flush_i && state_q != IDLE) begin
        state_q <= IDLE;
        ready_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (start_i && !flush_i) begin
            word_q   <= word_i;
            selrem_q <= rem_i;
            negq_q   <= sign_i && (a_msb ^ b_msb);
            negr_q   <= sign_i && a_msb;
            dz_q     <= dz;
            ov_q     <= ov;
            aext_q   <= aext;
            rem_q    <= '0;
            quo_q    <= quo_init;
            dvs_q    <= b_mag;
            cnt_q    <= word_i ? CNT_W'(32) : CNT_W'(XLEN);
            ready_q  <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            if (dz || ov || lt) begin
              result_q <= special(dz, ov, rem_i, aext);
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
`else
            state_q  <= CALC;
`endif
          end
          CALC: begin
            if (!diff[XLEN]) begin
              rem_q <= diff[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q <= trial[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_q <= FIX;
          end
          FIX: begin
            result_q <= fix_res;
            state_q  <= DONE;
          end
          DONE: begin
            vld_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ready_o     = ready_q;
  assign out_valid_o = vld_q;
  assign result_o    = result_q;
endmodule
